alu_control_unit: RTL and testbench
===================================

ALU_CONTROL_UNIT -- requirements
Module: alu_control_unit

Interface
REQ-001 The block SHALL have no parameters; operand width is fixed at 8 bits, with 8 iterations for multiply and divide.
REQ-002 clk  input  1  single clock; all state SHALL update on the posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  operation request, sampled only in IDLE.
REQ-005 op  input  2  operation select: 00 add, 01 sub, 10 multiply (Booth radix-2), 11 divide (restoring); sampled with start.
REQ-006 q0  input  1  datapath Q[0], used for the Booth pair.
REQ-007 q_1  input  1  datapath Q[-1], used for the Booth pair.
REQ-008 a_sign  input  1  datapath A[8] sign after the divide trial subtract.
REQ-009 cnt7  input  1  from the iteration counter; high when the count equals 7.
REQ-010 c  output  10  datapath and counter control strobes, one bit per micro-operation.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 Control bit meanings SHALL be:
- c[0]: load operands (A<=0, Q<=X, M<=Y, Q-1<=0)
- c[1]: A<=A+M
- c[2]: A<=A-M
- c[3]: arithmetic right shift A:Q:Q-1
- c[4]: left shift A:Q
- c[5]: Q[0]<=1
- c[6]: drive A to outbus
- c[7]: drive Q to outbus
- c[8]: multiply iteration count strobe
- c[9]: divide iteration count strobe
REQ-014 Each c bit SHALL be a single-cycle strobe; any c bit not listed for the current state SHALL be 0.
REQ-015 The FSM SHALL have these states: IDLE, LOAD, ADD, SUB, MTEST, MADD, MSUB, MSHIFT, DSHIFT, DSUB, DCHK, DREST, OUTA, OUTQ, DONE.
REQ-016 IDLE SHALL go to LOAD when start=1 and stay in IDLE otherwise; start SHALL be ignored in every other state.
REQ-017 LOAD SHALL assert c[0] and branch on the latched op: 00 to ADD, 01 to SUB, 10 to MTEST, 11 to DSHIFT.
REQ-018 ADD SHALL assert c[1] and go to OUTA; SUB SHALL assert c[2] and go to OUTA.
REQ-019 MTEST SHALL assert no strobes and branch on {q0,q_1}: 01 to MADD, 10 to MSUB, 00 or 11 to MSHIFT.
REQ-020 MADD SHALL assert c[1] and go to MSHIFT; MSUB SHALL assert c[2] and go to MSHIFT.
REQ-021 MSHIFT SHALL assert c[3] and c[8]; it SHALL go to OUTA if cnt7=1 (8th iteration), else to MTEST.
REQ-022 DSHIFT SHALL assert c[4] and go to DSUB; DSUB SHALL assert c[2] and go to DCHK.
REQ-023 DCHK with a_sign=0 SHALL assert c[5] and c[9] in the same cycle (Mealy outputs), then go to OUTA if cnt7=1, else to DSHIFT.
REQ-024 DCHK with a_sign=1 SHALL assert no strobes and go to DREST.
REQ-025 DREST SHALL assert c[1] and c[9], then go to OUTA if cnt7=1, else to DSHIFT.
REQ-026 OUTA SHALL assert c[6] and go to OUTQ; OUTQ SHALL assert c[7] and go to DONE.
REQ-027 DONE SHALL assert done=1 and go to IDLE; a start present in DONE SHALL be ignored.
REQ-028 Exactly 8 count strobes SHALL be issued per multiply or divide so that the external 3-bit counter wraps 7->0 and is at 0 for the next operation; add and sub SHALL issue none.
REQ-029 cnt7 SHALL be examined only in MSHIFT, DCHK (a_sign=0) and DREST.
REQ-030 op SHALL be registered on the start-accept edge; changes to op during busy SHALL have no effect.

Reset
REQ-031 When rst=1 at a posedge, the state SHALL become IDLE and op_reg SHALL become 00.
REQ-032 After reset, c SHALL be 0, busy 0 and done 0.
REQ-033 Reset SHALL abort any operation in progress, including mid-iteration, with no further strobes issued.
REQ-034 rst SHALL have priority over start in the same cycle.

Verification
REQ-035 Add: start=1, op=00 in IDLE -> c[0], c[1], c[6], c[7] pulse on cycles 1-4 after the accept edge; done=1 on cycle 5; busy high cycles 1-5.
REQ-036 Multiply with q0=q_1=0 held: done on cycle 20, 8 c[3]/c[8] pulses, no c[1]/c[2], modelled counter returns to 0.
REQ-037 Multiply with {q0,q_1}=10 held: every MTEST is followed by MSUB (c[2]), giving 8 c[2] pulses; done on cycle 28.
REQ-038 Divide with a_sign=0 held: 8 cycles with c[5] and c[9] both high, no c[1]; done on cycle 28.
REQ-039 Divide with a_sign=1 held: 8 DREST cycles with c[1] and c[9] both high, no c[5]; done on cycle 36.
REQ-040 rst=1 asserted during the 4th MSHIFT -> next cycle c=0, busy=0; a new add started afterwards completes correctly; start pulsed while busy -> no effect.

Source files
------------

// File: rtl/alu_control_unit.sv
// Sequencer for an 8-bit add/sub/Booth-multiply/restoring-divide datapath.
// Issues one-hot-per-micro-op strobes on c; an external 3-bit counter supplies cnt7.
module alu_control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] op,
   input  logic       q0,
   input  logic       q_1,
   input  logic       a_sign,
   input  logic       cnt7,
   output logic [9:0] c,
   output logic       busy,
   output logic       done,
   output logic [3:0] state_dbg
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_LOAD   = 4'd1;
   localparam logic [3:0] S_ADD    = 4'd2;
   localparam logic [3:0] S_SUB    = 4'd3;
   localparam logic [3:0] S_MTEST  = 4'd4;
   localparam logic [3:0] S_MADD   = 4'd5;
   localparam logic [3:0] S_MSUB   = 4'd6;
   localparam logic [3:0] S_MSHIFT = 4'd7;
   localparam logic [3:0] S_DSHIFT = 4'd8;
   localparam logic [3:0] S_DSUB   = 4'd9;
   localparam logic [3:0] S_DCHK   = 4'd10;
   localparam logic [3:0] S_DREST  = 4'd11;
   localparam logic [3:0] S_OUTA   = 4'd12;
   localparam logic [3:0] S_OUTQ   = 4'd13;
   localparam logic [3:0] S_DONE   = 4'd14;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic [1:0] op_reg;

   // Request handshake: start is accepted only while busy=0 (IDLE); the
   // accepting edge captures op, and further start pulses are ignored until
   // the cycle after done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         op_reg <= 2'b00;
      end else begin
         state <= state_nxt;
         if (state == S_IDLE && start)
            op_reg <= op;
      end
   end

   always_comb begin
      state_nxt = state;
      c         = '0;
      case (state)
         S_IDLE:   if (start) state_nxt = S_LOAD;
         S_LOAD: begin
            c[0] = 1'b1;
            case (op_reg)
               2'b00:   state_nxt = S_ADD;
               2'b01:   state_nxt = S_SUB;
               2'b10:   state_nxt = S_MTEST;
               default: state_nxt = S_DSHIFT;
            endcase
         end
         S_ADD: begin
            c[1]      = 1'b1;
            state_nxt = S_OUTA;
         end
         S_SUB: begin
            c[2]      = 1'b1;
            state_nxt = S_OUTA;
         end
         S_MTEST: begin
            case ({q0, q_1})
               2'b01:   state_nxt = S_MADD;
               2'b10:   state_nxt = S_MSUB;
               default: state_nxt = S_MSHIFT;
            endcase
         end
         S_MADD: begin
            c[1]      = 1'b1;
            state_nxt = S_MSHIFT;
         end
         S_MSUB: begin
            c[2]      = 1'b1;
            state_nxt = S_MSHIFT;
         end
         S_MSHIFT: begin
            c[3]      = 1'b1;
            c[8]      = 1'b1;
            state_nxt = cnt7 ? S_OUTA : S_MTEST;
         end
         S_DSHIFT: begin
            c[4]      = 1'b1;
            state_nxt = S_DSUB;
         end
         S_DSUB: begin
            c[2]      = 1'b1;
            state_nxt = S_DCHK;
         end
         // Trial subtract succeeded: set the quotient bit and count in the
         // same cycle; otherwise restore A first and count there.
         S_DCHK: begin
            if (!a_sign) begin
               c[5]      = 1'b1;
               c[9]      = 1'b1;
               state_nxt = cnt7 ? S_OUTA : S_DSHIFT;
            end else begin
               state_nxt = S_DREST;
            end
         end
         S_DREST: begin
            c[1]      = 1'b1;
            c[9]      = 1'b1;
            state_nxt = cnt7 ? S_OUTA : S_DSHIFT;
         end
         S_OUTA: begin
            c[6]      = 1'b1;
            state_nxt = S_OUTQ;
         end
         S_OUTQ: begin
            c[7]      = 1'b1;
            state_nxt = S_DONE;
         end
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign state_dbg = state;

endmodule

// File: tb/tb_alu_control_unit.sv
// Self-checking bench for alu_control_unit: directed vector table, randomized
// operations against an algorithm-level model, and reset/abort sequences.
module tb_alu_control_unit;

   logic       clk;
   logic       rst;
   logic       start;
   logic [1:0] op;
   logic       q0;
   logic       q_1;
   logic       a_sign;
   logic       cnt7;
   logic [9:0] c;
   logic       busy;
   logic       done;
   logic [3:0] state_dbg;

   int n_vec = 0;
   int n_err = 0;

   localparam logic [9:0] C_LD   = 10'h001;
   localparam logic [9:0] C_ADD  = 10'h002;
   localparam logic [9:0] C_SUB  = 10'h004;
   localparam logic [9:0] C_ASR  = 10'h008;
   localparam logic [9:0] C_SHL  = 10'h010;
   localparam logic [9:0] C_SETQ = 10'h020;
   localparam logic [9:0] C_OA   = 10'h040;
   localparam logic [9:0] C_OQ   = 10'h080;
   localparam logic [9:0] C_MC   = 10'h100;
   localparam logic [9:0] C_DC   = 10'h200;

   typedef struct {
      logic [1:0] op;
      logic       q0;
      logic       q_1;
      logic       a_sign;
      int         done_cyc;
      int         n_add;
      int         n_sub;
      int         n_asr;
      int         n_shl;
      int         n_setq;
      int         n_cnt;
   } vec_t;

   vec_t tbl[8];

   alu_control_unit dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .op        (op),
      .q0        (q0),
      .q_1       (q_1),
      .a_sign    (a_sign),
      .cnt7      (cnt7),
      .c         (c),
      .busy      (busy),
      .done      (done),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External 3-bit iteration counter, as the datapath would hold it.
   logic [2:0] ext_cnt;
   always @(posedge clk) begin
      if (rst)
         ext_cnt <= 3'd0;
      else if (c[8] | c[9])
         ext_cnt <= ext_cnt + 3'd1;
   end
   assign cnt7 = (ext_cnt == 3'd7);

   task automatic chk(input string nm, input logic [9:0] ec, input logic eb, input logic ed);
      n_vec++;
      if ({busy, done, c} !== {eb, ed, ec}) begin
         n_err++;
         $display("FAIL %s: got busy=%b done=%b c=%b, want busy=%b done=%b c=%b",
                  nm, busy, done, c, eb, ed, ec);
      end
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", nm, act, exp);
      end
   endtask

   // driver: next cycle with random datapath flags and a random (ignored) request
   task automatic next_cycle();
      @(negedge clk);
      start  = 1'($urandom_range(0, 1));
      op     = 2'($urandom_range(0, 3));
      q0     = 1'($urandom_range(0, 1));
      q_1    = 1'($urandom_range(0, 1));
      a_sign = 1'($urandom_range(0, 1));
      #1;
   endtask

   // Reference model: walks the algorithm (load, iterate 8 times, output A, Q)
   // and states the strobes each micro-step must produce.
   task automatic run_model(input logic [1:0] o);
      logic [1:0] pair;
      @(negedge clk);
      start = 1'b1;
      op    = o;
      #1;
      chk("idle_accept", '0, 1'b0, 1'b0);
      next_cycle();
      chk("load", C_LD, 1'b1, 1'b0);
      case (o)
         2'b00: begin next_cycle(); chk("add", C_ADD, 1'b1, 1'b0); end
         2'b01: begin next_cycle(); chk("sub", C_SUB, 1'b1, 1'b0); end
         2'b10: begin
            for (int i = 0; i < 8; i++) begin
               next_cycle();
               pair = {q0, q_1};
               chk("mtest", '0, 1'b1, 1'b0);
               if (pair == 2'b01) begin
                  next_cycle(); chk("madd", C_ADD, 1'b1, 1'b0);
               end else if (pair == 2'b10) begin
                  next_cycle(); chk("msub", C_SUB, 1'b1, 1'b0);
               end
               next_cycle();
               chk("mshift", C_ASR | C_MC, 1'b1, 1'b0);
            end
         end
         default: begin
            for (int i = 0; i < 8; i++) begin
               next_cycle(); chk("dshift", C_SHL, 1'b1, 1'b0);
               next_cycle(); chk("dsub", C_SUB, 1'b1, 1'b0);
               next_cycle();
               if (!a_sign) begin
                  chk("dchk_ok", C_SETQ | C_DC, 1'b1, 1'b0);
               end else begin
                  chk("dchk_neg", '0, 1'b1, 1'b0);
                  next_cycle(); chk("drest", C_ADD | C_DC, 1'b1, 1'b0);
               end
            end
         end
      endcase
      next_cycle(); chk("outa", C_OA, 1'b1, 1'b0);
      next_cycle(); chk("outq", C_OQ, 1'b1, 1'b0);
      next_cycle();
      start = 1'b1;
      chk("done", '0, 1'b1, 1'b1);
      @(negedge clk);
      start = 1'b0;
      #1;
      chk("idle_after", '0, 1'b0, 1'b0);
      chk_int("counter_wrap", int'(ext_cnt), 0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int done_at, busy_bad, n1, n2, n3, n4, n5, nc;
      string tag;
      tag = $sformatf("vec%0d", idx);
      done_at = 0; busy_bad = 0;
      n1 = 0; n2 = 0; n3 = 0; n4 = 0; n5 = 0; nc = 0;
      @(negedge clk);
      start = 1'b1; op = v.op; q0 = v.q0; q_1 = v.q_1; a_sign = v.a_sign;
      for (int cyc = 1; cyc <= 60 && done_at == 0; cyc++) begin
         @(negedge clk);
         start = 1'b0;
         #1;
         if (!busy) busy_bad++;
         n1 += int'(c[1]); n2 += int'(c[2]); n3 += int'(c[3]);
         n4 += int'(c[4]); n5 += int'(c[5]); nc += int'(c[8] | c[9]);
         if (done) done_at = cyc;
      end
      chk_int({tag, "_done_cycle"}, done_at, v.done_cyc);
      chk_int({tag, "_busy_low"}, busy_bad, 0);
      chk_int({tag, "_n_add"}, n1, v.n_add);
      chk_int({tag, "_n_sub"}, n2, v.n_sub);
      chk_int({tag, "_n_asr"}, n3, v.n_asr);
      chk_int({tag, "_n_shl"}, n4, v.n_shl);
      chk_int({tag, "_n_setq"}, n5, v.n_setq);
      chk_int({tag, "_n_cnt"}, nc, v.n_cnt);
      @(negedge clk);
      #1;
      chk({tag, "_idle"}, '0, 1'b0, 1'b0);
      chk_int({tag, "_counter"}, int'(ext_cnt), 0);
   endtask

   initial begin
      //          op     q0    q_1   asg   done add sub asr shl setq cnt
      tbl[0] = '{2'b00, 1'b0, 1'b0, 1'b0,  5,  1,  0,  0,  0,  0,  0};
      tbl[1] = '{2'b01, 1'b0, 1'b0, 1'b0,  5,  0,  1,  0,  0,  0,  0};
      tbl[2] = '{2'b10, 1'b0, 1'b0, 1'b0, 20,  0,  0,  8,  0,  0,  8};
      tbl[3] = '{2'b10, 1'b1, 1'b0, 1'b0, 28,  0,  8,  8,  0,  0,  8};
      tbl[4] = '{2'b10, 1'b0, 1'b1, 1'b0, 28,  8,  0,  8,  0,  0,  8};
      tbl[5] = '{2'b10, 1'b1, 1'b1, 1'b0, 20,  0,  0,  8,  0,  0,  8};
      tbl[6] = '{2'b11, 1'b0, 1'b0, 1'b0, 28,  0,  8,  0,  8,  8,  8};
      tbl[7] = '{2'b11, 1'b0, 1'b0, 1'b1, 36,  8,  8,  0,  8,  0,  8};

      rst = 1'b1; start = 1'b0; op = 2'b00; q0 = 1'b0; q_1 = 1'b0; a_sign = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_state", '0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

      for (int i = 0; i < 40; i++) run_model(2'($urandom_range(0, 3)));

      // Abort during the 4th MSHIFT, with start also high on the reset edge.
      begin
         int shifts;
         shifts = 0;
         @(negedge clk);
         start = 1'b1; op = 2'b10; q0 = 1'b0; q_1 = 1'b0;
         for (int cyc = 0; cyc < 40 && shifts < 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            if (c[3]) shifts++;
         end
         chk_int("abort_reached_4th_shift", shifts, 4);
         rst = 1'b1; start = 1'b1; op = 2'b11;
         @(negedge clk);
         #1;
         chk("abort_reset", '0, 1'b0, 1'b0);
         rst = 1'b0; start = 1'b0;
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("abort_quiet", '0, 1'b0, 1'b0);
         end
         run_model(2'b00);
         run_model(2'b01);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
